cd_rx_frame: RTL and testbench

Upstream stage of the RX frame buffer. It consumes bytes from the byte-level receiver, parses the header [src, dst, len], applies the address filter and accumulates CRC-16/MODBUS. It writes header and data bytes into the RX buffer (wr_byte/wr_addr/wr_en), then commits each frame with a switch pulse carrying wr_len and wr_err. The CRC bytes are never stored.

---
 rtl/cd_pkg.sv | 26 ++
 rtl/cd_crc.sv | 21 ++
 rtl/cd_rx_frame.sv | 175 +++++++++++++++++
 tb/tb_cd_rx_frame.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cd_pkg.sv
// cd_pkg: shared state encoding and constants for the cd frame datapath.
// Used by the RX parser and the CRC step that the TX side also reuses.
package cd_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR_SRC,
        HDR_DST,
        HDR_LEN,
        DATA,
        CRC_L,
        CRC_H,
        COMMIT,
        DROP
    } state_t;

    localparam logic [7:0]  SRC_OFF  = 8'd0;
    localparam logic [7:0]  DST_OFF  = 8'd1;
    localparam logic [7:0]  LEN_OFF  = 8'd2;
    localparam logic [7:0]  DATA_OFF = 8'd3;

    localparam logic [15:0] CRC_INIT = 16'hffff;
    localparam logic [15:0] CRC_POLY = 16'ha001;
    localparam logic [7:0]  BCAST    = 8'hff;

endpackage

// File: rtl/cd_crc.sv
// cd_crc: one-byte CRC-16/MODBUS step (reflected, poly 0xa001).
// Purely combinational; shared by the RX parser and the TX side.
module cd_crc
    import cd_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  din,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {8'h00, din};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/cd_rx_frame.sv
// cd_rx_frame: RX header parser, address filter and CRC check feeding the RX buffer.
// Define CD_RX_ERR_FRAME_EN to also commit CRC-failed frames with wr_err set.
module cd_rx_frame
    import cd_pkg::*;
#(
    parameter int MAX_DATA = 253
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_byte,
    input  logic       in_vld,
    input  logic       in_err,
    input  logic       bus_idle,
    input  logic [7:0] filter,
    input  logic [7:0] filter_m,
    input  logic       promisc,
    output logic [7:0] wr_byte,
    output logic [7:0] wr_addr,
    output logic       wr_en,
    output logic [7:0] wr_len,
    output logic       wr_err,
    output logic       switch,
    input  logic       switch_fail,
    output logic       crc_err,
    output logic       frame_err,
    output logic       lost
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_DATA);

`ifdef CD_RX_ERR_FRAME_EN
    localparam bit ERR_FRAME = 1'b1;
`else
    localparam bit ERR_FRAME = 1'b0;
`endif

    state_t      state;
    logic [15:0] crc;
    logic [15:0] crc_cur;
    logic [15:0] crc_nxt;
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [7:0]  cnt;
    logic [7:0]  idx;
    logic        pend_dst;
    logic        crc_bad;
    logic        accept;

    // A byte seen while still in IDLE starts a fresh CRC.
    assign crc_cur = (state == IDLE) ? CRC_INIT : crc;

    cd_crc u_crc (
        .crc_in  (crc_cur),
        .din     (in_byte),
        .crc_out (crc_nxt)
    );

    assign accept = promisc
                 || (in_byte == filter)
                 || (in_byte == BCAST)
                 || ((filter_m != BCAST) && (in_byte == filter_m));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            crc       <= CRC_INIT;
            src       <= 8'h00;
            dst       <= 8'h00;
            cnt       <= 8'h00;
            idx       <= 8'h00;
            pend_dst  <= 1'b0;
            crc_bad   <= 1'b0;
            wr_byte   <= 8'h00;
            wr_addr   <= 8'h00;
            wr_en     <= 1'b0;
            wr_len    <= 8'h00;
            wr_err    <= 1'b0;
            switch    <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            lost      <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            switch    <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            lost      <= switch_fail;

            // dst goes out the cycle after src; byte spacing keeps this slot free.
            if (pend_dst) begin
                wr_en    <= 1'b1;
                wr_byte  <= dst;
                wr_addr  <= DST_OFF;
                pend_dst <= 1'b0;
            end

            if (state == IDLE) begin
                crc <= CRC_INIT;
                if (!bus_idle) begin
                    if (in_vld) begin
                        src   <= in_byte;
                        crc   <= crc_nxt;
                        state <= HDR_DST;
                    end else begin
                        state <= HDR_SRC;
                    end
                end
            end else if (state == DROP) begin
                if (bus_idle) state <= IDLE;
            end else if (in_err) begin
                frame_err <= 1'b1;
                state     <= DROP;
            end else if (state == COMMIT) begin
                if (!crc_bad || ERR_FRAME) begin
                    switch <= 1'b1;
                    wr_len <= cnt;
                    wr_err <= crc_bad;
                end
                crc_err <= crc_bad;
                state   <= bus_idle ? IDLE : DROP;
            end else if (in_vld) begin
                crc <= crc_nxt;
                unique case (state)
                    HDR_SRC: begin
                        src   <= in_byte;
                        state <= HDR_DST;
                    end
                    HDR_DST: begin
                        dst <= in_byte;
                        if (accept) begin
                            wr_en    <= 1'b1;
                            wr_byte  <= src;
                            wr_addr  <= SRC_OFF;
                            pend_dst <= 1'b1;
                            state    <= HDR_LEN;
                        end else begin
                            state <= DROP;
                        end
                    end
                    HDR_LEN: begin
                        if (in_byte > MAX_LEN) begin
                            frame_err <= 1'b1;
                            state     <= DROP;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_byte <= in_byte;
                            wr_addr <= LEN_OFF;
                            cnt     <= in_byte;
                            idx     <= 8'h00;
                            state   <= (in_byte == 8'h00) ? CRC_L : DATA;
                        end
                    end
                    DATA: begin
                        wr_en   <= 1'b1;
                        wr_byte <= in_byte;
                        wr_addr <= DATA_OFF + idx;
                        idx     <= idx + 8'd1;
                        if (idx == cnt - 8'd1) state <= CRC_L;
                    end
                    CRC_L: state <= CRC_H;
                    CRC_H: begin
                        crc_bad <= (crc_nxt != 16'h0000);
                        state   <= COMMIT;
                    end
                    default: state <= DROP;
                endcase
            end else if (bus_idle) begin
                // Losing the bus before dst arrives is not an error.
                frame_err <= (state != HDR_SRC) && (state != HDR_DST);
                state     <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_cd_rx_frame.sv
// tb_cd_rx_frame: scoreboard bench for cd_rx_frame with a frame-level reference model.
// Honours CD_RX_ERR_FRAME_EN to pick the expected handling of CRC-failed frames.
`timescale 1ns/1ps
module tb_cd_rx_frame;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    localparam int K_WR = 0;
    localparam int K_SW = 1;
    localparam int K_CE = 2;
    localparam int K_FE = 3;
    localparam int K_LO = 4;

`ifdef CD_RX_ERR_FRAME_EN
    localparam bit ERR_FRAME = 1'b1;
`else
    localparam bit ERR_FRAME = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_vld = 1'b0;
    logic       in_err = 1'b0;
    logic       bus_idle = 1'b1;
    logic [7:0] filter = 8'h05;
    logic [7:0] filter_m = 8'hff;
    logic       promisc = 1'b0;
    logic       switch_fail = 1'b0;
    logic [7:0] wr_byte;
    logic [7:0] wr_addr;
    logic       wr_en;
    logic [7:0] wr_len;
    logic       wr_err;
    logic       switch;
    logic       crc_err;
    logic       frame_err;
    logic       lost;

    logic [15:0] u_crc_in = 16'hffff;
    logic [7:0]  u_din = 8'h00;
    logic [15:0] u_crc_out;

    always #5 clk = ~clk;

    cd_rx_frame dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_byte     (in_byte),
        .in_vld      (in_vld),
        .in_err      (in_err),
        .bus_idle    (bus_idle),
        .filter      (filter),
        .filter_m    (filter_m),
        .promisc     (promisc),
        .wr_byte     (wr_byte),
        .wr_addr     (wr_addr),
        .wr_en       (wr_en),
        .wr_len      (wr_len),
        .wr_err      (wr_err),
        .switch      (switch),
        .switch_fail (switch_fail),
        .crc_err     (crc_err),
        .frame_err   (frame_err),
        .lost        (lost)
    );

    cd_crc u_crc (
        .crc_in  (u_crc_in),
        .din     (u_din),
        .crc_out (u_crc_out)
    );

    int   checks = 0;
    int   failures = 0;
    ev_t  exp_q[$];
    bit   hold_chk = 1'b0;
    int   hold_len;
    int   hold_err;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input int a, input int b);
        ev_t e;
        e.kind = kind;
        e.a = a;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int a, input int b);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual=k%0d/%0h/%0h required=none",
                     kind, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == K_SW) begin
                hold_chk = 1'b1;
                hold_len = e.a;
                hold_err = e.b;
            end
            if (e.kind != kind || e.a != a || e.b != b) begin
                failures++;
                $display("FAIL event actual=k%0d/%0h/%0h required=k%0d/%0h/%0h",
                         kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    task automatic drain(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (hold_chk) begin
                hold_chk = 1'b0;
                check("hold_len", int'(wr_len), hold_len);
                check("hold_err", int'(wr_err), hold_err);
            end
            if (wr_en)     observe(K_WR, int'(wr_addr), int'(wr_byte));
            if (switch)    observe(K_SW, int'(wr_len), int'(wr_err));
            if (crc_err)   observe(K_CE, 0, 0);
            if (frame_err) observe(K_FE, 0, 0);
            if (lost)      observe(K_LO, 0, 0);
        end
    end

    function automatic logic [15:0] crc16(input bq_t q, input int n);
        logic [15:0] c;
        c = 16'hffff;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, q[i]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 16'ha001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic bq_t make_frame(input logic [7:0] s, input logic [7:0] d,
                                       input logic [7:0] l, input bq_t data);
        bq_t q;
        logic [15:0] c;
        q.push_back(s);
        q.push_back(d);
        q.push_back(l);
        foreach (data[i]) q.push_back(data[i]);
        c = crc16(q, q.size());
        q.push_back(c[7:0]);
        q.push_back(c[15:8]);
        return q;
    endfunction

    // Expected events for the bytes b, ended either by in_err or by bus idle.
    task automatic model(input bq_t b, input bit by_err);
        int n;
        int len;
        logic [7:0] d;
        logic [15:0] c;
        n = b.size();
        if (n < 2) begin
            if (by_err) push(K_FE, 0, 0);
            return;
        end
        d = b[1];
        if (!(promisc || d == filter || d == 8'hff ||
              (filter_m != 8'hff && d == filter_m))) return;
        push(K_WR, 0, int'(b[0]));
        push(K_WR, 1, int'(d));
        if (n < 3) begin
            push(K_FE, 0, 0);
            return;
        end
        len = int'(b[2]);
        if (len > 253) begin
            push(K_FE, 0, 0);
            return;
        end
        push(K_WR, 2, len);
        for (int k = 0; k < len && 3 + k < n; k++)
            push(K_WR, 3 + k, int'(b[3 + k]));
        if (n < len + 5) begin
            push(K_FE, 0, 0);
            return;
        end
        c = crc16(b, len + 3);
        if (b[len + 3] == c[7:0] && b[len + 4] == c[15:8]) begin
            push(K_SW, len, 0);
        end else begin
            if (ERR_FRAME) push(K_SW, len, 1);
            push(K_CE, 0, 0);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit idle_too);
        in_byte = v;
        in_vld = 1'b1;
        if (idle_too) bus_idle = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        repeat ($urandom_range(2, 3)) @(negedge clk);
    endtask

    task automatic run_frame(input bq_t b, input bit by_err, input bit idle_last);
        model(b, by_err);
        bus_idle = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < b.size(); i++)
            send_byte(b[i], idle_last && !by_err && (i == b.size() - 1));
        if (by_err) begin
            in_err = 1'b1;
            @(negedge clk);
            in_err = 1'b0;
            repeat (2) @(negedge clk);
        end
        bus_idle = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t   f;
        bq_t   d;
        bq_t   t;
        bit    seen;
        string s;
        int    n;

        s = "123456789";
        u_crc_in = 16'hffff;
        for (int i = 0; i < 9; i++) begin
            u_din = s[i];
            #1;
            u_crc_in = u_crc_out;
        end
        check("crc_123456789", int'(u_crc_in), 32'h4b37);

        repeat (2) @(negedge clk);
        check("reset_outs", int'({wr_byte, wr_addr, wr_en, wr_len, wr_err,
                                  switch, crc_err, frame_err, lost}), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        d = {8'haa, 8'hbb};
        f = make_frame(8'h01, 8'h05, 8'h02, d);
        run_frame(f, 1'b0, 1'b0);
        drain("good_frame");

        f = make_frame(8'h01, 8'h07, 8'h02, d);
        run_frame(f, 1'b0, 1'b0);
        drain("filtered");
        promisc = 1'b1;
        run_frame(f, 1'b0, 1'b0);
        drain("promisc");
        promisc = 1'b0;

        f = make_frame(8'h01, 8'h05, 8'h02, d);
        f[f.size() - 1] = f[f.size() - 1] ^ 8'h01;
        run_frame(f, 1'b0, 1'b0);
        drain("bad_crc");

        f = make_frame(8'h01, 8'h05, 8'hfe, d);
        run_frame(f, 1'b0, 1'b0);
        drain("len_fe");

        t = {8'h11, 8'h22, 8'h33};
        f = make_frame(8'h01, 8'h05, 8'h03, t);
        t = f[0:4];
        run_frame(t, 1'b0, 1'b0);
        drain("short_frame");
        run_frame(f, 1'b0, 1'b1);
        drain("after_short");

        f = make_frame(8'h09, 8'hff, 8'h01, t[0:0]);
        seen = 1'b0;
        fork
            run_frame(f, 1'b0, 1'b0);
            begin
                for (int i = 0; i < 300 && !seen; i++) begin
                    @(negedge clk);
                    seen = switch;
                end
                if (seen) begin
                    @(negedge clk);
                    switch_fail = 1'b1;
                    push(K_LO, 0, 0);
                    @(negedge clk);
                    switch_fail = 1'b0;
                end
            end
        join
        check("lost_switch_seen", int'(seen), 1);
        drain("lost");

        t = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        f = make_frame(8'h11, 8'h05, 8'h06, t);
        for (int i = 0; i < 5; i++) push(K_WR, i, int'(f[i]));
        bus_idle = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) send_byte(f[i], 1'b0);
        drain("pre_reset");
        reset_n = 1'b0;
        #1;
        check("reset_mid_outs", int'({wr_byte, wr_addr, wr_en, wr_len, wr_err,
                                      switch, crc_err, frame_err, lost}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        f = make_frame(8'h22, 8'h05, 8'h01, t[0:0]);
        run_frame(f, 1'b0, 1'b0);
        drain("after_reset");

        for (int it = 0; it < 60; it++) begin
            logic [7:0] dd;
            logic [7:0] l;
            int nd;
            bit be;
            bit il;
            filter   = 8'($urandom);
            filter_m = ($urandom_range(0, 2) == 0) ? 8'hff : 8'($urandom);
            promisc  = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 4))
                0:       dd = filter;
                1:       dd = 8'hff;
                2:       dd = filter_m;
                default: dd = 8'($urandom);
            endcase
            l = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(254, 255))
                                            : 8'($urandom_range(0, 8));
            nd = (l > 8'd253) ? 2 : int'(l);
            d = {};
            for (int i = 0; i < nd; i++) d.push_back(8'($urandom));
            f = make_frame(8'($urandom), dd, l, d);
            if ($urandom_range(0, 4) == 0) begin
                n = f.size() - 1 - int'($urandom_range(0, 1));
                f[n] = f[n] ^ 8'(1 << $urandom_range(0, 7));
            end
            if ($urandom_range(0, 5) == 0) begin
                n = int'($urandom_range(0, f.size() - 1));
                while (f.size() > n) void'(f.pop_back());
            end else if ($urandom_range(0, 5) == 0) begin
                f.push_back(8'($urandom));
            end
            be = ($urandom_range(0, 7) == 0);
            il = ($urandom_range(0, 3) == 0);
            run_frame(f, be, il);
            drain("rand_frame");
        end

        repeat (10) @(negedge clk);
        drain("final_queue");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
